// File: rtl/conv_ctrl_param_if.sv
// Bundle of the layer-sequencer handshake, the packed feature-memory read
// data and the controller outputs toward address generators, memories and
// the multiply-accumulate array.
//
// Handshake: the sequencer raises go for one cycle while busy is low; the
// controller raises busy on the next edge and keeps it high until the cycle
// after its single-cycle done pulse. go seen while busy is high is dropped.
interface conv_ctrl_param_if #(
    parameter int DATA_WIDTH           = 16,
    parameter int INPUT_NUM_MEM        = 6,
    parameter int IFMAP_PAR            = 2,
    parameter int COUNT_SLOAD_BITWIDTH = 8
);
    logic                                go;
    logic                                hold;
    logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all;
    logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all;
    logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all;
    logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all;
    logic                                busy;
    logic                                done;
    logic                                enable_addrger;
    logic                                enable_weightaddrger;
    logic                                in_feature_rden;
    logic                                weight_rden;
    logic                                enable_mult;
    logic                                accum_sload;
    logic [COUNT_SLOAD_BITWIDTH-1:0]     count_sload;
    logic                                pixel_strobe;

    // Sequencer / memory side.
    modport master (
        output go, hold, in_feature_q_a_all, in_feature_q_b_all,
        input  in_feature_q_a_mux_all, in_feature_q_b_mux_all, busy, done,
               enable_addrger, enable_weightaddrger, in_feature_rden,
               weight_rden, enable_mult, accum_sload, count_sload, pixel_strobe
    );

    // Controller side.
    modport slave (
        input  go, hold, in_feature_q_a_all, in_feature_q_b_all,
        output in_feature_q_a_mux_all, in_feature_q_b_mux_all, busy, done,
               enable_addrger, enable_weightaddrger, in_feature_rden,
               weight_rden, enable_mult, accum_sload, count_sload, pixel_strobe
    );
endinterface

// File: rtl/conv_ctrl_param.sv
// Convolution-layer controller: sequences one layer pass (fill, MAC run,
// drain) from go to done, time-multiplexes memory groups onto multiplier
// lanes and delays the per-pixel completion event to match the datapath.
module conv_ctrl_param #(
    parameter int DATA_WIDTH                = 16,
    parameter int INPUT_NUM_MEM             = 6,
    parameter int IFMAP_PAR                 = 2,
    parameter int NUM_ONE_PIXEL_CYCLE_INTER = 25,
    parameter int OUT_FEATURE_WIDTH         = 24,
    parameter int NUM_ONEMULT               = 1,
    parameter int PIPE_DELAY                = 4,
    parameter int COUNT_SLOAD_BITWIDTH      = 8
) (
    input logic              clock,
    input logic              reset,
    conv_ctrl_param_if.slave bus
);
    localparam int G       = INPUT_NUM_MEM / IFMAP_PAR;
    localparam int PIX_CYC = G * NUM_ONE_PIXEL_CYCLE_INTER;
    localparam int TOTAL   = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
    localparam int CW      = COUNT_SLOAD_BITWIDTH;
    localparam int PIX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PH_W    = $clog2(PIPE_DELAY + 2);
    localparam int LANE_W  = DATA_WIDTH * IFMAP_PAR;

    localparam logic [CW-1:0]    TAP_LAST   = CW'(PIX_CYC - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(TOTAL - 1);
    localparam logic [PH_W-1:0]  FILL_LAST  = PH_W'(PIPE_DELAY - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(PIPE_DELAY);
    localparam logic [CW-1:0]    INTER_CW   = CW'(NUM_ONE_PIXEL_CYCLE_INTER);

    // Reject configurations the counters and mux cannot represent.
    if (INPUT_NUM_MEM % IFMAP_PAR != 0) begin : g_bad_par
        $error("INPUT_NUM_MEM must be a multiple of IFMAP_PAR");
    end
    if (PIPE_DELAY < 1) begin : g_bad_delay
        $error("PIPE_DELAY must be at least 1");
    end
    if (PIX_CYC - 1 >= (1 << COUNT_SLOAD_BITWIDTH)) begin : g_bad_count
        $error("COUNT_SLOAD_BITWIDTH too narrow for the tap count");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [PH_W-1:0]     phase;
    logic [CW-1:0]       tap;
    logic [PIX_W-1:0]    pixel;
    logic                busy_q;
    logic                done_q;
    logic [PIPE_DELAY:0] strobe_sr;

    logic          fill_st;
    logic          run_st;
    logic          drain_st;
    logic          run_go;
    logic          pix_event;
    logic [CW-1:0] grp;
    logic [LANE_W-1:0] mux_a;
    logic [LANE_W-1:0] mux_b;

    assign fill_st   = (state == S_FILL);
    assign run_st    = (state == S_RUN);
    assign drain_st  = (state == S_DRAIN);
    assign run_go    = run_st && !bus.hold;
    assign pix_event = run_go && (tap == TAP_LAST);

    // Pass sequencer: state, fill/drain phase, tap and pixel counters, busy/done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            phase  <= '0;
            tap    <= '0;
            pixel  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        state  <= S_FILL;
                        phase  <= '0;
                        tap    <= '0;
                        pixel  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (phase == FILL_LAST) begin
                        state <= S_RUN;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_RUN: begin
                    // Tap wrap, pixel step and the final exit share one edge.
                    if (!bus.hold) begin
                        if (tap == TAP_LAST) begin
                            tap <= '0;
                            if (pixel == PIX_LAST) begin
                                pixel <= '0;
                                state <= S_DRAIN;
                            end else begin
                                pixel <= pixel + 1'b1;
                            end
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (phase == DRAIN_LAST) begin
                        state  <= S_DONE;
                        phase  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Per-pixel event delay line, frozen together with the counters on hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_sr <= '0;
        end else if (!(run_st && bus.hold)) begin
            strobe_sr <= {strobe_sr[PIPE_DELAY-1:0], pix_event};
        end
    end

    assign grp = tap / INTER_CW;

    // Lane mux: the active memory group feeds the lanes only during RUN.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        if (run_st) begin
            for (int g = 0; g < G; g++) begin
                if (grp == CW'(g)) begin
                    mux_a = bus.in_feature_q_a_all[g*LANE_W +: LANE_W];
                    mux_b = bus.in_feature_q_b_all[g*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign bus.in_feature_q_a_mux_all = mux_a;
    assign bus.in_feature_q_b_mux_all = mux_b;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.in_feature_rden        = fill_st || run_st || drain_st;
    assign bus.weight_rden            = fill_st || run_st || drain_st;
    assign bus.enable_addrger         = fill_st || run_go;
    assign bus.enable_weightaddrger   = fill_st || run_go;
    assign bus.enable_mult            = run_go || drain_st;
    assign bus.accum_sload            = run_go && (tap == '0);
    assign bus.count_sload            = tap;
    assign bus.pixel_strobe           = strobe_sr[PIPE_DELAY];

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Bench for conv_ctrl_param in a small configuration (4 memories, 2 lanes,
// 2 taps per group, 2x2 output, pipe delay 2). A per-pass timeline model
// built from the pass rules supplies every expected output cycle by cycle.
module tb_conv_ctrl_param;
    localparam int DW = 16, NM = 4, P = 2, INTER = 2, OFW = 2, NOM = 1, PD = 2, CW = 8;
    localparam int G = NM / P, PIX_CYC = G * INTER, TOTAL = OFW * OFW * NOM;
    localparam int MAXC = 64;

    logic clock;
    logic reset;
    logic [DW*NM-1:0] mem_a, mem_b;

    conv_ctrl_param_if #(.DATA_WIDTH(DW), .INPUT_NUM_MEM(NM), .IFMAP_PAR(P),
                         .COUNT_SLOAD_BITWIDTH(CW)) bus ();

    conv_ctrl_param #(
        .DATA_WIDTH(DW), .INPUT_NUM_MEM(NM), .IFMAP_PAR(P),
        .NUM_ONE_PIXEL_CYCLE_INTER(INTER), .OUT_FEATURE_WIDTH(OFW),
        .NUM_ONEMULT(NOM), .PIPE_DELAY(PD), .COUNT_SLOAD_BITWIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    assign bus.in_feature_q_a_all = mem_a;
    assign bus.in_feature_q_b_all = mem_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus patterns indexed by cycle t (t = 1 is the first cycle after go is sampled)
    logic hold_pat[MAXC];
    logic go_pat[MAXC];
    // reference timeline
    logic e_busy[MAXC], e_done[MAXC], e_rden[MAXC], e_addr[MAXC], e_mult[MAXC];
    logic e_sload[MAXC], e_strobe[MAXC], e_run[MAXC], frz[MAXC], ev[MAXC];
    int   e_count[MAXC];
    int   m_done_t;
    // observations of the last pass
    int obs_done_t, obs_first_str, obs_n_done, obs_n_str;
    logic [DW*P-1:0] lane_g0_a, lane_g1_a, lane_g0_b, lane_g1_b;

    function automatic logic [8:0] act_ctl();
        return {bus.busy, bus.done, bus.in_feature_rden, bus.weight_rden,
                bus.enable_addrger, bus.enable_weightaddrger, bus.enable_mult,
                bus.accum_sload, bus.pixel_strobe};
    endfunction

    task automatic clear_pats();
        for (int i = 0; i < MAXC; i++) begin
            hold_pat[i] = 1'b0;
            go_pat[i]   = 1'b0;
        end
    endtask

    // Timeline: FILL for PD cycles, then every non-held RUN cycle issues the
    // next tap until TOTAL*PIX_CYC taps are out, PD+1 DRAIN cycles, one DONE.
    task automatic build_model();
        int t, k, p, ts;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_rden[i] = 0; e_addr[i] = 0; e_mult[i] = 0;
            e_sload[i] = 0; e_strobe[i] = 0; e_run[i] = 0; frz[i] = 0; ev[i] = 0;
            e_count[i] = 0;
        end
        for (t = 1; t <= PD; t++) begin
            e_busy[t] = 1; e_rden[t] = 1; e_addr[t] = 1;
        end
        k = 0;
        t = PD + 1;
        while (k < TOTAL * PIX_CYC) begin
            e_busy[t] = 1; e_rden[t] = 1; e_run[t] = 1; e_count[t] = k % PIX_CYC;
            if (hold_pat[t]) begin
                frz[t] = 1;
            end else begin
                e_addr[t]  = 1;
                e_mult[t]  = 1;
                e_sload[t] = (k % PIX_CYC == 0);
                ev[t]      = (k % PIX_CYC == PIX_CYC - 1);
                k++;
            end
            t++;
        end
        repeat (PD + 1) begin
            e_busy[t] = 1; e_rden[t] = 1; e_mult[t] = 1;
            t++;
        end
        e_busy[t] = 1;
        e_done[t] = 1;
        m_done_t  = t;
        // each pixel event surfaces after PD+1 non-frozen shifts, and stays
        // visible while the delay line is frozen
        for (int t0 = 1; t0 < m_done_t; t0++) begin
            if (ev[t0]) begin
                p  = 0;
                ts = t0 + 1;
                while (p < PD) begin
                    if (!frz[ts]) p++;
                    ts++;
                end
                e_strobe[ts] = 1;
                while (frz[ts]) begin
                    ts++;
                    e_strobe[ts] = 1;
                end
            end
        end
    endtask

    // Caller has go=1 in the current cycle; checks through the IDLE cycle after done.
    task automatic run_pass(input string tag);
        logic [8:0]      exp_ctl;
        logic [DW*P-1:0] exp_a, exp_b;
        int g;
        build_model();
        obs_done_t = -1; obs_first_str = -1; obs_n_done = 0; obs_n_str = 0;
        for (int t = 1; t <= m_done_t + 1; t++) begin
            @(posedge clock);
            #1;
            bus.go   = go_pat[t];
            bus.hold = hold_pat[t];
            #1;
            exp_ctl = {e_busy[t], e_done[t], e_rden[t], e_rden[t], e_addr[t], e_addr[t],
                       e_mult[t], e_sload[t], e_strobe[t]};
            n_tests++;
            if (act_ctl() !== exp_ctl) begin
                n_fail++;
                $display("FAIL %s ctl t=%0d got %b expected %b (busy,done,rden,wrden,addr,waddr,mult,sload,strobe)",
                         tag, t, act_ctl(), exp_ctl);
            end
            n_tests++;
            if (bus.count_sload !== CW'(e_count[t])) begin
                n_fail++;
                $display("FAIL %s count_sload t=%0d got %0d expected %0d", tag, t, bus.count_sload, e_count[t]);
            end
            exp_a = '0;
            exp_b = '0;
            if (e_run[t]) begin
                g = e_count[t] / INTER;
                for (int k = 0; k < P; k++) begin
                    exp_a[k*DW +: DW] = mem_a[(g*P+k)*DW +: DW];
                    exp_b[k*DW +: DW] = mem_b[(g*P+k)*DW +: DW];
                end
            end
            n_tests++;
            if (bus.in_feature_q_a_mux_all !== exp_a || bus.in_feature_q_b_mux_all !== exp_b) begin
                n_fail++;
                $display("FAIL %s lanes t=%0d got a=%h b=%h expected a=%h b=%h", tag, t,
                         bus.in_feature_q_a_mux_all, bus.in_feature_q_b_mux_all, exp_a, exp_b);
            end
            if (bus.done === 1'b1) begin
                obs_n_done++;
                if (obs_done_t < 0) obs_done_t = t;
            end
            if (bus.pixel_strobe === 1'b1) begin
                if (obs_first_str < 0) obs_first_str = t;
                if (!(e_run[t] && hold_pat[t])) obs_n_str++;
            end
            if (e_run[t] && e_count[t] == 0 && !hold_pat[t]) begin
                lane_g0_a = bus.in_feature_q_a_mux_all;
                lane_g0_b = bus.in_feature_q_b_mux_all;
            end
            if (e_run[t] && e_count[t] == INTER && !hold_pat[t]) begin
                lane_g1_a = bus.in_feature_q_a_mux_all;
                lane_g1_b = bus.in_feature_q_b_mux_all;
            end
        end
        n_tests++;
        if (obs_n_str != TOTAL) begin
            n_fail++;
            $display("FAIL %s strobe_count got %0d expected %0d", tag, obs_n_str, TOTAL);
        end
    endtask

    task automatic test_reset();
        bus.go = 0; bus.hold = 0; mem_a = '1; mem_b = '1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        n_tests++;
        if (act_ctl() !== 9'b0 || bus.count_sload !== '0) begin
            n_fail++;
            $display("FAIL reset ctl got %b cnt %0d expected 0 cnt 0", act_ctl(), bus.count_sload);
        end
        n_tests++;
        if (bus.in_feature_q_a_mux_all !== '0 || bus.in_feature_q_b_mux_all !== '0) begin
            n_fail++;
            $display("FAIL reset lanes got %h %h expected 0", bus.in_feature_q_a_mux_all, bus.in_feature_q_b_mux_all);
        end
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        for (int m = 0; m < NM; m++) begin
            mem_a[m*DW +: DW] = DW'(16'h10 + m);
            mem_b[m*DW +: DW] = DW'(16'h30 + m);
        end
        clear_pats();
        bus.go = 1;
        run_pass("basic");
        n_tests++;
        if (obs_done_t != 22) begin
            n_fail++;
            $display("FAIL basic done_cycle got %0d expected 22", obs_done_t);
        end
        n_tests++;
        if (obs_first_str != 9) begin
            n_fail++;
            $display("FAIL basic first_strobe got %0d expected 9", obs_first_str);
        end
        n_tests++;
        if (lane_g0_a !== 32'h0011_0010 || lane_g0_b !== 32'h0031_0030) begin
            n_fail++;
            $display("FAIL basic lanes_grp0 got %h %h expected 00110010 00310030", lane_g0_a, lane_g0_b);
        end
        n_tests++;
        if (lane_g1_a !== 32'h0013_0012 || lane_g1_b !== 32'h0033_0032) begin
            n_fail++;
            $display("FAIL basic lanes_grp1 got %h %h expected 00130012 00330032", lane_g1_a, lane_g1_b);
        end
    endtask

    task automatic test_hold();
        // RUN starts at t=3; pixel 2 tap 1 is the 10th RUN cycle, t=12
        clear_pats();
        hold_pat[12] = 1; hold_pat[13] = 1; hold_pat[14] = 1;
        bus.go = 1;
        run_pass("hold");
        n_tests++;
        if (obs_done_t != 25) begin
            n_fail++;
            $display("FAIL hold done_cycle got %0d expected 25", obs_done_t);
        end
    endtask

    task automatic test_hold_fill_drain();
        clear_pats();
        hold_pat[1] = 1; hold_pat[2] = 1;
        hold_pat[19] = 1; hold_pat[20] = 1; hold_pat[21] = 1;
        bus.go = 1;
        run_pass("hold_fd");
        n_tests++;
        if (obs_done_t != 22) begin
            n_fail++;
            $display("FAIL hold_fd done_cycle got %0d expected 22", obs_done_t);
        end
    endtask

    task automatic test_ignored_go();
        clear_pats();
        go_pat[1] = 1; go_pat[5] = 1; go_pat[10] = 1; go_pat[22] = 1; go_pat[23] = 1;
        bus.go = 1;
        run_pass("ign_go");
        n_tests++;
        if (obs_n_done != 1) begin
            n_fail++;
            $display("FAIL ign_go done_pulses got %0d expected 1", obs_n_done);
        end
        // go held in the IDLE cycle after done starts the next pass immediately
        clear_pats();
        run_pass("back_to_back");
        n_tests++;
        if (obs_done_t != 22) begin
            n_fail++;
            $display("FAIL back_to_back done_cycle got %0d expected 22", obs_done_t);
        end
    endtask

    task automatic test_random();
        int n_h;
        for (int pass = 0; pass < 5; pass++) begin
            for (int m = 0; m < NM; m++) begin
                mem_a[m*DW +: DW] = DW'($urandom_range(0, 65535));
                mem_b[m*DW +: DW] = DW'($urandom_range(0, 65535));
            end
            clear_pats();
            n_h = 0;
            for (int t = 1; t < 40; t++) begin
                if ($urandom_range(0, 3) == 0 && n_h < 12) begin
                    hold_pat[t] = 1;
                    n_h++;
                end
            end
            for (int t = 1; t <= 20; t++) go_pat[t] = ($urandom_range(0, 4) == 0);
            bus.go = 1;
            run_pass($sformatf("rand%0d", pass));
        end
        bus.hold = 0;
        bus.go   = 0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        clear_pats();
        bus.go = 1;
        for (int t = 1; t <= PD + 5; t++) begin
            @(posedge clock);
            #1;
            bus.go = 0;
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (act_ctl() !== 9'b0 || bus.count_sload !== '0) begin
            n_fail++;
            $display("FAIL midrst ctl got %b cnt %0d expected 0 cnt 0", act_ctl(), bus.count_sload);
        end
        n_tests++;
        if (bus.in_feature_q_a_mux_all !== '0 || bus.in_feature_q_b_mux_all !== '0) begin
            n_fail++;
            $display("FAIL midrst lanes got %h %h expected 0", bus.in_feature_q_a_mux_all, bus.in_feature_q_b_mux_all);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clock);
            #2;
            if (bus.done !== 1'b0 || bus.pixel_strobe !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst quiet got %0d active cycles expected 0", seen);
        end
        bus.go = 1;
        run_pass("post_reset");
        n_tests++;
        if (obs_done_t != 22) begin
            n_fail++;
            $display("FAIL post_reset done_cycle got %0d expected 22", obs_done_t);
        end
        bus.go = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_hold_fill_drain();
        test_ignored_go();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
